// File: rtl/branch_predictor_perceptron_p_pkg.sv
// Shared types and helpers for the hashed perceptron branch predictor.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package branch_pred_pkg;

    // BranchOutcome normally comes from mips_core_pkg. That package is not part
    // of this bundle, so an encoding-compatible copy lives here.
    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

    localparam int ADDR_WIDTH = 32;

    // Default geometry. The weight type below is sized from these defaults.
    localparam int HIST_LEN_DEF = 16;
    localparam int IDX_BITS_DEF = 6;
    localparam int W_BITS       = 8;
    localparam int THETA_DEF    = 44;
    localparam int CNT_BITS_DEF = 32;

    // Width of the dot product. It holds (H+1) full-scale weights without overflow.
    localparam int Y_BITS = W_BITS + $clog2(HIST_LEN_DEF + 2);

    typedef logic signed [W_BITS-1:0] w_t;

    localparam w_t W_MAX = w_t'((2 ** (W_BITS - 1)) - 1);
    localparam w_t W_MIN = w_t'(-(2 ** (W_BITS - 1)));

    // Step a weight by +1 (up=1) or -1 (up=0). The result clamps at the range
    // ends instead of wrapping.
    function automatic w_t sat_add(w_t w, logic up);
        w_t r;
        if (up) r = (w == W_MAX) ? w : w + w_t'(1);
        else    r = (w == W_MIN) ? w : w - w_t'(1);
        return r;
    endfunction

endpackage

// File: rtl/branch_predictor_perceptron_p_if.sv
// Request/feedback slot bundle between branch_controller and the predictor.
// Latency: wires only; the prediction returns combinationally in the request cycle.
// Backpressure: none; a request or a feedback is accepted on every cycle it is valid.
interface branch_predictor_perceptron_p_if
    import branch_pred_pkg::*;
#(
    parameter int AW = ADDR_WIDTH,
    parameter int CW = CNT_BITS_DEF
) ();
    logic           i_req_valid;
    logic [AW-1:0]  i_req_pc;
    logic [AW-1:0]  i_req_target;
    BranchOutcome   o_req_prediction;
    logic           i_fb_valid;
    logic [AW-1:0]  i_fb_pc;
    BranchOutcome   i_fb_prediction;
    BranchOutcome   i_fb_outcome;
    logic [CW-1:0]  o_pred_count;
    logic [CW-1:0]  o_miss_count;

    modport master (
        output i_req_valid, i_req_pc, i_req_target,
        output i_fb_valid, i_fb_pc, i_fb_prediction, i_fb_outcome,
        input  o_req_prediction, o_pred_count, o_miss_count
    );

    modport slave (
        input  i_req_valid, i_req_pc, i_req_target,
        input  i_fb_valid, i_fb_pc, i_fb_prediction, i_fb_outcome,
        output o_req_prediction, o_pred_count, o_miss_count
    );
endinterface

// File: rtl/branch_predictor_perceptron_p_dot.sv
// Signed dot product of one perceptron row with the history vector plus the bias.
// Latency: combinational.
// Backpressure: n/a.
module perceptron_dot
    import branch_pred_pkg::*;
#(
    parameter int HIST_LEN = HIST_LEN_DEF,
    parameter int W_BITS   = branch_pred_pkg::W_BITS,
    parameter int Y_BITS   = branch_pred_pkg::Y_BITS
) (
    input  logic [(HIST_LEN+1)*W_BITS-1:0] row_i,
    input  logic [HIST_LEN-1:0]            ghr_i,
    output logic signed [Y_BITS-1:0]       y_o
);
    logic signed [Y_BITS-1:0] acc;
    logic signed [Y_BITS-1:0] wx;

    // The bias input is always +1. Each history bit adds its weight when TAKEN
    // and subtracts it when NOT_TAKEN.
    always_comb begin
        acc = {{(Y_BITS-W_BITS){row_i[W_BITS-1]}}, row_i[W_BITS-1:0]};
        wx  = '0;
        for (int i = 1; i <= HIST_LEN; i++) begin
            wx = {{(Y_BITS-W_BITS){row_i[i*W_BITS+W_BITS-1]}}, row_i[i*W_BITS +: W_BITS]};
            if (ghr_i[i-1]) acc = acc + wx;
            else            acc = acc - wx;
        end
        y_o = acc;
    end
endmodule

// File: rtl/branch_predictor_perceptron_p.sv
// Hashed perceptron branch predictor with a bias weight, saturating weights and a 2-stage trainer.
// Latency: prediction is combinational; a training write lands 1 cycle after its feedback.
// Backpressure: none; one feedback is absorbed per cycle, and same-row overlap is handled by forwarding.
module branch_predictor_perceptron_p
    import branch_pred_pkg::*;
#(
    parameter int HIST_LEN = HIST_LEN_DEF,
    parameter int IDX_BITS = IDX_BITS_DEF,
    parameter int W_BITS   = branch_pred_pkg::W_BITS,  // must equal the width of w_t
    parameter int THETA    = THETA_DEF,
    parameter int CNT_BITS = CNT_BITS_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    branch_predictor_perceptron_p_if.slave bp
);
    localparam int ROWS  = 1 << IDX_BITS;
    localparam int ROW_W = (HIST_LEN + 1) * W_BITS;
    localparam int Y_W   = W_BITS + $clog2(HIST_LEN + 2);
    localparam logic signed [Y_W-1:0] TH_P = Y_W'(THETA);
    localparam logic signed [Y_W-1:0] TH_N = -TH_P;

    logic [ROW_W-1:0]    tbl_q [ROWS];
    logic [HIST_LEN-1:0] ghr_q, ghr_d;

    logic                s2_vld_q, s2_train_q, s2_out_q;
    logic [IDX_BITS-1:0] s2_row_q;
    logic [HIST_LEN-1:0] s2_ghr_q;

    logic [CNT_BITS-1:0] pred_cnt_q, pred_cnt_d;
    logic [CNT_BITS-1:0] miss_cnt_q, miss_cnt_d;

    logic [IDX_BITS-1:0]  req_row, fb_row;
    logic signed [Y_W-1:0] req_y, fb_y;
    logic [ROW_W-1:0]     s2_old, upd_row, fb_src;
    logic                 fb_fwd, fb_miss, fb_train;
    w_t                   wcur;
    logic                 unused_pc_bits;

    assign req_row = bp.i_req_pc[IDX_BITS+1:2];
    assign fb_row  = bp.i_fb_pc[IDX_BITS+1:2];

    // The request path reads only registered state, so it never sees a write
    // that lands on the same edge.
    perceptron_dot #(.HIST_LEN(HIST_LEN), .W_BITS(W_BITS), .Y_BITS(Y_W)) u_dot_req (
        .row_i (tbl_q[req_row]),
        .ghr_i (ghr_q),
        .y_o   (req_y)
    );
    assign bp.o_req_prediction = req_y[Y_W-1] ? NOT_TAKEN : TAKEN;

    // Stage-2 row update: w += t*x_i with saturation. t*x_i is +1 exactly when
    // the input agrees with the outcome.
    assign s2_old = tbl_q[s2_row_q];
    always_comb begin
        upd_row = s2_old;
        wcur    = w_t'(s2_old[W_BITS-1:0]);
        upd_row[W_BITS-1:0] = sat_add(wcur, s2_out_q);
        for (int i = 1; i <= HIST_LEN; i++) begin
            wcur = w_t'(s2_old[i*W_BITS +: W_BITS]);
            upd_row[i*W_BITS +: W_BITS] = sat_add(wcur, s2_ghr_q[i-1] == s2_out_q);
        end
    end

    // Stage 1 reads the row that stage 2 is about to write. Back-to-back
    // feedbacks to the same row then behave as if processed one at a time.
    assign fb_fwd = s2_vld_q && s2_train_q && (s2_row_q == fb_row);
    assign fb_src = fb_fwd ? upd_row : tbl_q[fb_row];

    perceptron_dot #(.HIST_LEN(HIST_LEN), .W_BITS(W_BITS), .Y_BITS(Y_W)) u_dot_fb (
        .row_i (fb_src),
        .ghr_i (ghr_q),
        .y_o   (fb_y)
    );

    assign fb_miss  = (bp.i_fb_prediction != bp.i_fb_outcome);
    assign fb_train = fb_miss || ((fb_y >= TH_N) && (fb_y <= TH_P));
    assign ghr_d    = bp.i_fb_valid ? {ghr_q[HIST_LEN-2:0], bp.i_fb_outcome == TAKEN} : ghr_q;

    assign pred_cnt_d = (bp.i_req_valid && (pred_cnt_q != '1)) ? pred_cnt_q + CNT_BITS'(1) : pred_cnt_q;
    assign miss_cnt_d = (bp.i_fb_valid && fb_miss && (miss_cnt_q != '1)) ? miss_cnt_q + CNT_BITS'(1) : miss_cnt_q;

    // Weight table: the stage-2 write port. Reset clears every row and drops
    // any pending write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++) tbl_q[r] <= '0;
        end else if (s2_vld_q && s2_train_q) begin
            tbl_q[s2_row_q] <= upd_row;
        end
    end

    // Stage-1 to stage-2 register, the history shift and the statistics counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld_q   <= 1'b0;
            s2_train_q <= 1'b0;
            s2_out_q   <= 1'b0;
            s2_row_q   <= '0;
            s2_ghr_q   <= '0;
            ghr_q      <= '0;
            pred_cnt_q <= '0;
            miss_cnt_q <= '0;
        end else begin
            s2_vld_q   <= bp.i_fb_valid;
            s2_train_q <= fb_train;
            s2_out_q   <= (bp.i_fb_outcome == TAKEN);
            s2_row_q   <= fb_row;
            s2_ghr_q   <= ghr_q;
            ghr_q      <= ghr_d;
            pred_cnt_q <= pred_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign bp.o_pred_count = pred_cnt_q;
    assign bp.o_miss_count = miss_cnt_q;

    // The target and the PC bits outside the index do not feed the predictor.
    assign unused_pc_bits = ^{bp.i_req_target,
                              bp.i_req_pc[ADDR_WIDTH-1:IDX_BITS+2], bp.i_req_pc[1:0],
                              bp.i_fb_pc[ADDR_WIDTH-1:IDX_BITS+2],  bp.i_fb_pc[1:0]};
endmodule

// File: tb/tb_branch_predictor_perceptron_p.sv
// Bench for the perceptron predictor: directed patterns plus random traffic, checked against a serial model.
// Latency: model predictions use the weight view committed one cycle after each feedback.
// Backpressure: n/a; stimulus is applied every cycle.
module tb_branch_predictor_perceptron_p;
    import branch_pred_pkg::*;

    localparam int H  = 16;
    localparam int NR = 64;
    localparam int TH = 44;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_predictor_perceptron_p_if bp ();

    branch_predictor_perceptron_p dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bp.slave)
    );

    // The model trains serially in mw. vw is what the prediction port can see;
    // it takes on a trained row one cycle after the feedback.
    int          mw [NR][H+1];
    int          vw [NR][H+1];
    int          mghr [H];          // mghr[0] is the newest outcome
    int unsigned m_pred, m_miss;
    bit          pend_vld;
    int          pend_row;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int row_of(logic [31:0] pc);
        return int'(pc[7:2]);
    endfunction

    function automatic int dot(bit vis, int r);
        int s;
        s = vis ? vw[r][0] : mw[r][0];
        for (int i = 1; i <= H; i++) begin
            int w;
            w = vis ? vw[r][i] : mw[r][i];
            s += (mghr[i-1] != 0) ? w : -w;
        end
        return s;
    endfunction

    function automatic bit exp_pred(logic [31:0] pc);
        return dot(1'b1, row_of(pc)) >= 0;
    endfunction

    function automatic logic [159:0] pack_row(int r);
        logic [159:0] p;
        int v;
        p = '0;
        for (int i = 0; i <= H; i++) begin
            v = vw[r][i];
            p[i*8 +: 8] = v[7:0];
        end
        return p;
    endfunction

    function automatic logic [159:0] pack_ghr();
        logic [159:0] g;
        g = '0;
        for (int i = 0; i < H; i++) g[i] = (mghr[i] != 0);
        return g;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NR; r++)
            for (int i = 0; i <= H; i++) begin
                mw[r][i] = 0;
                vw[r][i] = 0;
            end
        for (int i = 0; i < H; i++) mghr[i] = 0;
        m_pred = 0;
        m_miss = 0;
        pend_vld = 1'b0;
        pend_row = 0;
    endtask

    // One clock edge of the abstract predictor.
    task automatic model_edge(bit rv, bit fv, logic [31:0] fpc, bit fp, bit fo);
        int r, y, ay, nv, x, t;
        bit train;
        if (pend_vld)
            for (int i = 0; i <= H; i++) vw[pend_row][i] = mw[pend_row][i];
        pend_vld = 1'b0;
        if (rv && m_pred != 32'hffff_ffff) m_pred++;
        if (fv) begin
            r  = row_of(fpc);
            y  = dot(1'b0, r);
            ay = (y < 0) ? -y : y;
            train = (fp != fo) || (ay <= TH);
            if (fp != fo) m_miss++;
            if (train) begin
                t = fo ? 1 : -1;
                for (int i = 0; i <= H; i++) begin
                    x  = (i == 0) ? 1 : ((mghr[i-1] != 0) ? 1 : -1);
                    nv = mw[r][i] + t * x;
                    if (nv > 127)  nv = 127;
                    if (nv < -128) nv = -128;
                    mw[r][i] = nv;
                end
            end
            pend_vld = 1'b1;
            pend_row = r;
            for (int i = H - 1; i > 0; i--) mghr[i] = mghr[i-1];
            mghr[0] = fo ? 1 : 0;
        end
    endtask

    // Apply one cycle of stimulus. Outputs are checked at the falling edge and
    // the model advances at the rising edge.
    task automatic step(input bit rv, input logic [31:0] rpc, input bit fv, input logic [31:0] fpc,
                        input bit fp, input bit fo, input string tag, output bit obs);
        bp.i_req_valid     = rv;
        bp.i_req_pc        = rpc;
        bp.i_req_target    = $urandom;
        bp.i_fb_valid      = fv;
        bp.i_fb_pc         = fpc;
        bp.i_fb_prediction = fp ? TAKEN : NOT_TAKEN;
        bp.i_fb_outcome    = fo ? TAKEN : NOT_TAKEN;
        @(negedge clk);
        obs = (bp.o_req_prediction == TAKEN);
        chk({tag, ":pred"}, bp.o_req_prediction, exp_pred(rpc));
        chk({tag, ":pcnt"}, bp.o_pred_count, m_pred);
        chk({tag, ":mcnt"}, bp.o_miss_count, m_miss);
        @(posedge clk);
        model_edge(rv, fv, fpc, fp, fo);
        #1;
    endtask

    logic [31:0] pcs [4] = '{32'h40, 32'h44, 32'h80, 32'h1040};

    initial begin
        bit o;
        bit fo, fp;
        logic [31:0] pc;

        model_reset();
        bp.i_req_valid = 0; bp.i_req_pc = 0; bp.i_req_target = 0;
        bp.i_fb_valid = 0; bp.i_fb_pc = 0;
        bp.i_fb_prediction = NOT_TAKEN; bp.i_fb_outcome = NOT_TAKEN;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Right after reset: every PC predicts TAKEN and both counters read 0.
        for (int k = 0; k < 8; k++) begin
            pc = $urandom;
            step(1'b0, pc, 1'b0, 32'h0, 1'b0, 1'b0, "rst", o);
            chk("rst_taken", o, 1'b1);
        end

        // 50 NOT_TAKEN feedbacks at 0x40, each predicted TAKEN.
        for (int k = 0; k < 50; k++)
            step(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 1'b0, "nt40", o);
        step(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0, "nt40_idle", o);
        chk("nt40_final_pred", o, 1'b0);
        chk("nt40_miss50", bp.o_miss_count, 50);
        chk("nt40_row", dut.tbl_q[16], pack_row(16));

        // Taken streak at 0x3C: training stops on its own once |y| exceeds THETA.
        // A forced mispredict streak then drives every weight to the clamp.
        for (int k = 0; k < 200; k++)
            step(1'b1, 32'h3C, 1'b1, 32'h3C, 1'b1, 1'b1, "sat_t", o);
        chk("sat_row_soft", dut.tbl_q[15], pack_row(15));
        for (int k = 0; k < 200; k++)
            step(1'b0, 32'h3C, 1'b1, 32'h3C, 1'b0, 1'b1, "sat_f", o);
        step(1'b1, 32'h3C, 1'b0, 32'h0, 1'b0, 1'b0, "sat_idle", o);
        chk("sat_bias127", dut.tbl_q[15][7:0], 8'd127);
        chk("sat_row", dut.tbl_q[15], pack_row(15));

        // Same-row back-to-back feedbacks T,N,T at 0x80. The first round is forced
        // to mispredict so that every one of them trains.
        for (int rep = 0; rep < 4; rep++) begin
            for (int j = 0; j < 3; j++) begin
                fo = (j != 1);
                fp = (rep == 0) ? !fo : 1'($urandom_range(0, 1));
                step(1'b0, 32'h80, 1'b1, 32'h80, fp, fo, "b2b", o);
            end
            step(1'b0, 32'h80, 1'b0, 32'h0, 1'b0, 1'b0, "b2b_idle", o);
            chk("b2b_row", dut.tbl_q[32], pack_row(32));
        end

        // Alternating outcomes at 0x100. Once trained, each prediction matches the outcome.
        for (int k = 0; k < 64; k++) begin
            fo = (k % 2 == 0);
            fp = exp_pred(32'h100);
            step(1'b1, 32'h100, 1'b1, 32'h100, fp, fo, "alt", o);
            if (k >= 48) chk("alt_learned", o, fo);
        end

        // Random traffic over a few rows, including aliasing PCs 0x40 and 0x1040.
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 1)), pcs[$urandom_range(0, 3)],
                 1'($urandom_range(0, 3) != 0), pcs[$urandom_range(0, 3)],
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rnd", o);
        end
        chk("rnd_row16", dut.tbl_q[16], pack_row(16));
        chk("rnd_row17", dut.tbl_q[17], pack_row(17));
        chk("rnd_row32", dut.tbl_q[32], pack_row(32));
        chk("rnd_ghr", dut.ghr_q, pack_ghr());

        // Reset in the cycle after a training feedback: the pending write is lost
        // and the outputs return to their reset values without a clock edge.
        step(1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 1'b0, "prerst", o);
        bp.i_fb_valid = 1'b0;
        bp.i_req_pc   = 32'h40;
        #1;
        chk("prerst_pred", bp.o_req_prediction, exp_pred(32'h40));
        rst_n = 1'b0;
        #1;
        chk("arst_pred", bp.o_req_prediction, TAKEN);
        chk("arst_pcnt", bp.o_pred_count, 0);
        chk("arst_mcnt", bp.o_miss_count, 0);
        chk("arst_ghr", dut.ghr_q, 0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0, "postrst", o);
        step(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0, "postrst2", o);
        chk("postrst_row16", dut.tbl_q[16], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
